// File: rtl/wait_stall_ctrl_if.sv
// wait_stall_ctrl_if
// Bundles the execute-stage handshake of the multi-cycle mult/div stall
// controller.
//   master : pipeline side, drives req_valid / req_is_div / flush and
//            observes stall / wait_en / busy / done / stall_cnt
//   slave  : the controller itself
interface wait_stall_ctrl_if;
    logic        req_valid;
    logic        req_is_div;
    logic        flush;
    logic        stall;
    logic        wait_en;
    logic        busy;
    logic        done;
    logic [31:0] stall_cnt;

    modport master (
        output req_valid, req_is_div, flush,
        input  stall, wait_en, busy, done, stall_cnt
    );

    modport slave (
        input  req_valid, req_is_div, flush,
        output stall, wait_en, busy, done, stall_cnt
    );
endinterface

// File: rtl/wait_stall_ctrl.sv
// wait_stall_ctrl
// Freezes the upstream pipeline while a multi-cycle multiply or divide
// executes, then emits a one-cycle done pulse for result capture.
// Ports:
//   clk    : single clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : wait_stall_ctrl_if.slave
//            req_valid/req_is_div/flush in, stall/wait_en (comb),
//            busy (registered), done (pulse), stall_cnt (32-bit perf count)
// Parameters:
//   MUL_CYCLES (1..64), DIV_CYCLES (1..64) : execute cycles per op type
// Build option:
//   WAIT_STALL_PERF_CNT_EN defined   -> stall_cnt counts stalled cycles
//                                       (saturating, cleared by reset)
//   WAIT_STALL_PERF_CNT_EN undefined -> stall_cnt is tied to zero
module wait_stall_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic                   clk,
    input  logic                   resetn,
    wait_stall_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter holds "cycles remaining minus one", so 64 cycles fit in 6 bits.
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 32'd1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 32'd1);

    state_e      state_q;
    state_e      state_d;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_d;
    logic        busy_q;
    logic        busy_d;
    logic        stall_s;

    // Next-state and down-counter logic; flush overrides every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cnt_d   = bus.req_is_div ? DIV_LOAD : MUL_LOAD;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_q != 6'd0) begin
                        cnt_d = cnt_q - 6'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter and busy flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Gating with resetn keeps the pipeline unfrozen while reset is held,
    // even if an upstream req_valid is still asserted.
    assign stall_s     = resetn && !bus.flush &&
                         (((state_q == ST_IDLE) && bus.req_valid) || (state_q == ST_RUN));
    assign bus.stall   = stall_s;
    assign bus.wait_en = ~stall_s;
    assign bus.busy    = busy_q;
    // A flush landing on the DONE cycle suppresses the capture pulse.
    assign bus.done    = (state_q == ST_DONE) && !bus.flush;

`ifdef WAIT_STALL_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // Saturating stalled-cycle counter.
    always_comb begin
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule
